// File: rtl/time_set_ctrl.sv
// time_set_ctrl: button-driven hour/minute/second preset editor that issues
// load pulses to the counter chain and drives field-select/blink for the display.
module time_set_ctrl #(
  parameter int PE_LEN    = 2,
  parameter int BLINK_DIV = 25000000,
  parameter int TIMEOUT   = 500000000
) (
  input  logic       clk,
  input  logic       CR,
  input  logic       btn_mode,
  input  logic       btn_sel,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic [7:0] cur_hour,
  input  logic [7:0] cur_min,
  input  logic [7:0] cur_sec,
  output logic [7:0] pre_hour,
  output logic [7:0] pre_min,
  output logic [7:0] pre_sec,
  output logic       PE_hour,
  output logic       PE_min,
  output logic       PE_sec,
  output logic       set_mode,
  output logic [1:0] field_sel,
  output logic       blink
);
  localparam logic [2:0] S_RUN    = 3'd0;
  localparam logic [2:0] S_HOUR   = 3'd1;
  localparam logic [2:0] S_MIN    = 3'd2;
  localparam logic [2:0] S_SEC    = 3'd3;
  localparam logic [2:0] S_COMMIT = 3'd4;
  localparam logic [31:0] IDLE_LAST  = 32'(TIMEOUT - 1);
  localparam logic [31:0] BLINK_LAST = 32'(BLINK_DIV - 1);
  localparam logic [3:0]  PE_LAST    = 4'(PE_LEN - 1);

  logic [2:0]  r_state;
  logic [3:0]  r_btn_q;
  logic [31:0] r_idle;
  logic [31:0] r_blink_cnt;
  logic [3:0]  r_pe_cnt;
  logic        r_blink;
  logic [7:0]  r_pre_hour;
  logic [7:0]  r_pre_min;
  logic [7:0]  r_pre_sec;
  logic [3:0]  w_btn;
  logic [3:0]  w_press;
  logic        w_edit;
  logic        w_step;
  logic [7:0]  w_sel_val;
  logic [7:0]  w_max;
  logic [7:0]  w_new_val;

  // button vector order: {mode, sel, inc, dec}
  assign w_btn     = {btn_mode, btn_sel, btn_inc, btn_dec};
  assign w_press   = w_btn & ~r_btn_q;
  assign w_edit    = (r_state == S_HOUR) || (r_state == S_MIN) || (r_state == S_SEC);
  assign w_step    = w_press[1] ^ w_press[0];
  assign w_sel_val = (r_state == S_HOUR) ? r_pre_hour : (r_state == S_MIN) ? r_pre_min : r_pre_sec;
  assign w_max     = (r_state == S_HOUR) ? 8'd23 : 8'd59;
  assign w_new_val = w_press[1] ? ((w_sel_val == w_max) ? 8'd0 : w_sel_val + 8'd1)
                                : ((w_sel_val == 8'd0) ? w_max : w_sel_val - 8'd1);

  always_ff @(posedge clk) begin
    if (CR) begin
      r_state     <= S_RUN;
      r_btn_q     <= 4'hF;
      r_idle      <= '0;
      r_blink_cnt <= '0;
      r_pe_cnt    <= '0;
      r_blink     <= 1'b0;
      r_pre_hour  <= '0;
      r_pre_min   <= '0;
      r_pre_sec   <= '0;
    end else begin
      r_btn_q <= w_btn;
      case (r_state)
        S_RUN: begin
          if (w_press[3]) begin
            r_pre_hour  <= (cur_hour > 8'd23) ? 8'd0 : cur_hour;
            r_pre_min   <= (cur_min > 8'd59) ? 8'd0 : cur_min;
            r_pre_sec   <= (cur_sec > 8'd59) ? 8'd0 : cur_sec;
            r_state     <= S_HOUR;
            r_idle      <= '0;
            r_blink_cnt <= '0;
            r_blink     <= 1'b0;
          end
        end
        S_COMMIT: begin
          r_pe_cnt <= r_pe_cnt + 4'd1;
          if (r_pe_cnt == PE_LAST) r_state <= S_RUN;
        end
        S_HOUR, S_MIN, S_SEC: begin
          r_blink_cnt <= (r_blink_cnt == BLINK_LAST) ? 32'd0 : r_blink_cnt + 32'd1;
          if (r_blink_cnt == BLINK_LAST) r_blink <= ~r_blink;
          r_idle <= (w_press != 4'd0) ? 32'd0 : r_idle + 32'd1;
          // mode beats sel beats inc/dec
          if (w_press[3]) begin
            r_state  <= S_COMMIT;
            r_pe_cnt <= '0;
            r_blink  <= 1'b0;
          end else if (w_press[2]) begin
            r_state <= (r_state == S_SEC) ? S_HOUR : r_state + 3'd1;
          end else if (w_step) begin
            if (r_state == S_HOUR) r_pre_hour <= w_new_val;
            if (r_state == S_MIN) r_pre_min <= w_new_val;
            if (r_state == S_SEC) r_pre_sec <= w_new_val;
          end
          if (w_press == 4'd0 && r_idle == IDLE_LAST) begin
            r_state <= S_RUN;
            r_blink <= 1'b0;
          end
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

  assign pre_hour  = r_pre_hour;
  assign pre_min   = r_pre_min;
  assign pre_sec   = r_pre_sec;
  assign PE_hour   = (r_state == S_COMMIT);
  assign PE_min    = (r_state == S_COMMIT);
  assign PE_sec    = (r_state == S_COMMIT);
  assign set_mode  = w_edit;
  assign field_sel = w_edit ? r_state[1:0] : 2'd0;
  assign blink     = r_blink;
endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: directed plus random stimulus against a cycle-level reference model
module tb_time_set_ctrl;
  localparam int PE_LEN    = 2;
  localparam int BLINK_DIV = 10;
  localparam int TIMEOUT   = 100;

  logic       clk = 1'b0;
  logic       CR = 1'b1;
  logic       btn_mode = 1'b0, btn_sel = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0;
  logic [7:0] cur_hour = 8'd0, cur_min = 8'd0, cur_sec = 8'd0;
  logic [7:0] pre_hour, pre_min, pre_sec;
  logic       PE_hour, PE_min, PE_sec, set_mode, blink;
  logic [1:0] field_sel;

  time_set_ctrl #(.PE_LEN(PE_LEN), .BLINK_DIV(BLINK_DIV), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .CR(CR), .btn_mode(btn_mode), .btn_sel(btn_sel), .btn_inc(btn_inc),
    .btn_dec(btn_dec), .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
    .pre_hour(pre_hour), .pre_min(pre_min), .pre_sec(pre_sec), .PE_hour(PE_hour),
    .PE_min(PE_min), .PE_sec(PE_sec), .set_mode(set_mode), .field_sel(field_sel),
    .blink(blink)
  );

  always #5 clk = ~clk;

  logic [30:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cycle = 0;
  logic pe_seen = 1'b0;

  int  vals[3];
  int  mods[3] = '{24, 60, 60};
  logic m_edit = 0, m_commit = 0;
  int  m_field = 0, m_left = 0, m_idle = 0, m_age = 0;
  logic [3:0] prev = 4'hF, b_now, p_now;

  always @(posedge clk) if (PE_hour | PE_min | PE_sec) pe_seen <= 1'b1;

  always @(posedge clk) begin
    cycle++;
    b_now = {btn_mode, btn_sel, btn_inc, btn_dec};
    if (CR) begin
      m_edit = 0; m_commit = 0; m_left = 0; prev = 4'hF;
      vals[0] = 0; vals[1] = 0; vals[2] = 0;
    end else begin
      p_now = b_now & ~prev;
      prev = b_now;
      if (m_commit) begin
        m_left--;
        if (m_left == 0) m_commit = 0;
      end else if (m_edit) begin
        m_age++;
        if (p_now[3]) begin
          m_edit = 0; m_commit = 1; m_left = PE_LEN;
        end else if (p_now != 0) begin
          m_idle = 0;
          if (p_now[2]) m_field = (m_field + 1) % 3;
          else if (p_now[1] != p_now[0])
            vals[m_field] = (vals[m_field] + (p_now[1] ? 1 : mods[m_field] - 1)) % mods[m_field];
        end else if (m_idle == TIMEOUT - 1) m_edit = 0;
        else m_idle++;
      end else if (p_now[3]) begin
        vals[0] = (int'(cur_hour) < 24) ? int'(cur_hour) : 0;
        vals[1] = (int'(cur_min) < 60) ? int'(cur_min) : 0;
        vals[2] = (int'(cur_sec) < 60) ? int'(cur_sec) : 0;
        m_edit = 1; m_field = 0; m_idle = 0; m_age = 0;
      end
    end
    exp_q.push_back({8'(vals[0]), 8'(vals[1]), 8'(vals[2]), {3{m_commit}}, m_edit,
                     m_edit ? 2'(m_field + 1) : 2'd0,
                     m_edit && ((m_age / BLINK_DIV) % 2 == 1)});
  end

  logic [30:0] act, want;
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      want = exp_q.pop_front();
      act = {pre_hour, pre_min, pre_sec, PE_hour, PE_min, PE_sec, set_mode, field_sel, blink};
      checks++;
      if (act !== want) begin
        errors++;
        $display("FAIL outputs cycle %0d: got pre=%0d:%0d:%0d PE=%b set=%b sel=%0d blink=%b, want pre=%0d:%0d:%0d PE=%b set=%b sel=%0d blink=%b",
                 cycle, act[30:23], act[22:15], act[14:7], act[6:4], act[3], act[2:1], act[0],
                 want[30:23], want[22:15], want[14:7], want[6:4], want[3], want[2:1], want[0]);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h want %h", name, cycle, got, exp);
    end
  endtask

  task automatic drive(input logic cr, input logic [3:0] b, input int n);
    CR = cr;
    {btn_mode, btn_sel, btn_inc, btn_dec} = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tap(input logic [3:0] b);
    drive(0, b, 1);
    drive(0, 4'b0000, 1);
  endtask

  logic [3:0] rb;
  initial begin
    cur_hour = 8'd13; cur_min = 8'd45; cur_sec = 8'd7;
    drive(1, 4'b1000, 3);
    check("reset_state", 32'({pre_hour, pre_min, pre_sec, PE_hour, PE_min, PE_sec, set_mode, field_sel, blink}), 32'd0);
    drive(0, 4'b1000, 4);
    drive(0, 4'b0000, 2);
    tap(4'b1000);
    repeat (11) tap(4'b0010);
    tap(4'b1000);
    drive(0, 4'b0000, 5);
    cur_min = 8'd0;
    tap(4'b1000);
    tap(4'b0100);
    tap(4'b0001);
    tap(4'b0100);
    tap(4'b0100);
    tap(4'b0011);
    tap(4'b1000);
    drive(0, 4'b0000, 4);
    cur_hour = 8'd24;
    tap(4'b1000);
    tap(4'b1010);
    drive(0, 4'b0000, 4);
    pe_seen = 1'b0;
    tap(4'b1000);
    drive(0, 4'b0000, 110);
    check("expired_wait", 32'({pe_seen, PE_hour, PE_min, PE_sec, set_mode, field_sel, blink}), 32'd0);
    tap(4'b1000);
    tap(4'b0010);
    drive(0, 4'b1000, 1);
    drive(1, 4'b0000, 1);
    drive(0, 4'b0000, 4);
    rb = 4'b0000;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 29) == 0) rb[$urandom_range(0, 3)] ^= 1'b1;
      if ($urandom_range(0, 199) == 0) begin
        cur_hour = 8'($urandom_range(0, 30));
        cur_min  = 8'($urandom_range(0, 70));
        cur_sec  = 8'($urandom_range(0, 70));
      end
      drive($urandom_range(0, 999) == 0, rb, 1);
    end
    drive(0, 4'b0000, 3);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
